button_event_arbiter: RTL

Central controller for the front-panel button debouncers feeding the VGA driver.
- Generates the shared one-cycle sample tick that clocks every debouncer.
- Resynchronises the debounced button levels and converts them into press, repeat and release events.
- Round-robins those events onto one valid/ready event channel consumed by the display control logic (cursor/mode FSM).

---
 rtl/button_event_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/button_event_arbiter.sv
// Front-panel button controller: shared debouncer sample tick, press/repeat/release
// event extraction and round-robin delivery on one valid/ready channel.
// Auto-repeat is built only when BTN_AUTO_REPEAT_EN is defined.
module button_event_arbiter #(
   parameter int NUM_BTN      = 4,
   parameter int SAMPLE_DIV   = 262144,
   parameter int REPEAT_DELAY = 64,
   parameter int REPEAT_RATE  = 8
) (
   input  logic                       clk,
   input  logic                       clr,
   output logic                       sample_tick,
   input  logic [NUM_BTN-1:0]         btn_db,
   output logic                       evt_valid,
   input  logic                       evt_ready,
   output logic [$clog2(NUM_BTN)-1:0] evt_id,
   output logic [1:0]                 evt_kind,
   output logic [NUM_BTN-1:0]         pending,
   input  logic                       ovr_clr,
   output logic                       overrun,
   output logic                       dbg_state
);

   localparam int IDW = $clog2(NUM_BTN);
   localparam int TCW = $clog2(SAMPLE_DIV);
   localparam logic [TCW-1:0] TICK_LAST = TCW'(SAMPLE_DIV - 1);
   localparam logic [1:0] K_PRESS   = 2'b01;
   localparam logic [1:0] K_REPEAT  = 2'b10;
   localparam logic [1:0] K_RELEASE = 2'b11;

   typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

   // ---------------- sample tick ----------------
   logic [TCW-1:0] tick_cnt;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         tick_cnt    <= '0;
         sample_tick <= 1'b0;
      end else begin
         sample_tick <= (tick_cnt == TICK_LAST);
         tick_cnt    <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
      end
   end

   // ---------------- input path ----------------
   logic [NUM_BTN-1:0] sync1, sync2, prev;
   logic [1:0]         arm_cnt;
   logic               ev_en;
   logic [NUM_BTN-1:0] rise, fall, rpt;

   // Edges stay suppressed until prev has reloaded from a settled sync chain,
   // so buttons already held at reset release raise no press.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync1   <= '0;
         sync2   <= '0;
         prev    <= '0;
         arm_cnt <= 2'd0;
      end else begin
         sync1 <= btn_db;
         sync2 <= sync1;
         prev  <= sync2;
         if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
      end
   end

   assign ev_en = (arm_cnt == 2'd3);
   assign rise  = sync2 & ~prev & {NUM_BTN{ev_en}};
   assign fall  = ~sync2 & prev & {NUM_BTN{ev_en}};

   // ---------------- auto-repeat ----------------
`ifdef BTN_AUTO_REPEAT_EN
   localparam int RCW = $clog2(REPEAT_DELAY + 1);
   localparam logic [RCW-1:0] REP_LAST   = RCW'(REPEAT_DELAY - 1);
   localparam logic [RCW-1:0] REP_RELOAD = RCW'(REPEAT_DELAY - REPEAT_RATE);

   logic [NUM_BTN-1:0] held;
   logic [RCW-1:0]     rep_cnt [NUM_BTN];

   assign held = sync2 & prev;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < NUM_BTN; i++) rep_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if (rise[i] || fall[i])
               rep_cnt[i] <= '0;
            else if (sample_tick && held[i])
               rep_cnt[i] <= (rep_cnt[i] == REP_LAST) ? REP_RELOAD : rep_cnt[i] + 1'b1;
         end
      end
   end

   always_comb begin
      rpt = '0;
      for (int i = 0; i < NUM_BTN; i++)
         rpt[i] = sample_tick && held[i] && ev_en && (rep_cnt[i] == REP_LAST);
   end
`else
   assign rpt = '0;
`endif

   // ---------------- pending slots ----------------
   logic [NUM_BTN-1:0] slot_vld, slot_rpt, take;
   logic [1:0]         slot_kind [NUM_BTN];
   logic               ovr_set;

   always_comb begin
      slot_rpt = '0;
      for (int i = 0; i < NUM_BTN; i++)
         slot_rpt[i] = slot_vld[i] && (slot_kind[i] == K_REPEAT);
   end

   // A slot emptied by the arbiter this cycle counts as free for incoming events.
   assign ovr_set = |((rise | fall) & slot_vld & ~slot_rpt & ~take);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         slot_vld <= '0;
         for (int i = 0; i < NUM_BTN; i++) slot_kind[i] <= 2'b00;
         overrun  <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if (rise[i] || fall[i]) begin
               slot_vld[i]  <= 1'b1;
               slot_kind[i] <= rise[i] ? K_PRESS : K_RELEASE;
            end else if (rpt[i] && !(slot_vld[i] && !take[i])) begin
               slot_vld[i]  <= 1'b1;
               slot_kind[i] <= K_REPEAT;
            end else if (take[i]) begin
               slot_vld[i]  <= 1'b0;
            end
         end
         if (ovr_set)      overrun <= 1'b1;
         else if (ovr_clr) overrun <= 1'b0;
      end
   end

   assign pending = slot_vld;

   // ---------------- arbiter ----------------
   // Channel: an event transfers on a clk edge where evt_valid && evt_ready;
   // once raised, evt_valid/evt_id/evt_kind stay stable until that transfer,
   // and evt_ready is ignored while evt_valid is low.
   state_t         state;
   logic [IDW-1:0] ptr, grant_idx;
   logic [1:0]     grant_kind;
   logic           found;

   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < NUM_BTN; k++) begin
         int j;
         j = int'(ptr) + k;
         if (j >= NUM_BTN) j = j - NUM_BTN;
         if (!found && slot_vld[j]) begin
            found     = 1'b1;
            grant_idx = IDW'(j);
         end
      end
      grant_kind = slot_kind[grant_idx];
      take       = (state == IDLE && found) ? (NUM_BTN'(1) << grant_idx) : '0;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= IDLE;
         evt_valid <= 1'b0;
         evt_id    <= '0;
         evt_kind  <= 2'b00;
         ptr       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  evt_id    <= grant_idx;
                  evt_kind  <= grant_kind;
                  evt_valid <= 1'b1;
                  state     <= OFFER;
               end
            end
            OFFER: begin
               if (evt_ready) begin
                  evt_valid <= 1'b0;
                  ptr       <= (evt_id == IDW'(NUM_BTN - 1)) ? '0 : evt_id + 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dbg_state = state;

endmodule
